// File: rtl/fmt_25b_pkg.sv
// rtl/fmt_25b_pkg.sv - 25-bit float word fields, FSM states and helpers
// Word layout: [25] sign, [24:17] exponent (bias 127), [16:0] fraction with
// hidden 1. An exponent of zero encodes zero; no denormals, inf or NaN.
package fmt_25b_pkg;

    localparam int WORD_W   = 26;
    localparam int SIGN_BIT = 25;
    localparam int EXP_MSB  = 24;
    localparam int EXP_LSB  = 17;
    localparam int EXP_W    = 8;
    localparam int FRAC_W   = 17;

    // Exponent arithmetic is carried in signed 10 bits so that over- and
    // underflow stay visible before packing.
    localparam logic signed [9:0] BIAS    = 10'sd127;
    localparam logic signed [9:0] EXP_MAX = 10'sd254;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT1,
        ST_DIV,
        ST_TRACK
    } state_t;

    function automatic logic is_zero(input word_t w);
        return w[EXP_MSB:EXP_LSB] == '0;
    endfunction

    // Packs a sign / wide exponent / fraction triple, saturating to the
    // largest magnitude above EXP_MAX and flushing to zero below 1.
    function automatic word_t pack(input logic s, input logic signed [9:0] e,
                                   input logic [FRAC_W-1:0] f);
        if (e > EXP_MAX)
            return {s, 8'hFE, {FRAC_W{1'b1}}};
        else if (e < 10'sd1)
            return '0;
        else
            return {s, e[EXP_W-1:0], f};
    endfunction

endpackage

// File: rtl/est_exp_25b_if.sv
// rtl/est_exp_25b_if.sv - sample stream handshake for est_exp_25b
// i_valid : sample valid (master -> slave)
// i_val   : sample word  (master -> slave)
// o_ready : slave can accept (slave -> master)
interface est_exp_25b_if;
    import fmt_25b_pkg::*;

    logic  i_valid;
    logic  o_ready;
    word_t i_val;

    modport master (output i_valid, output i_val, input o_ready);
    modport slave  (input i_valid, input i_val, output o_ready);
endinterface

// File: rtl/div_man_25b.sv
// rtl/div_man_25b.sv - iterative 18-bit restoring mantissa divider
// i_start : load operands (ignored while busy)
// i_num   : dividend mantissa 1.f, i_den : divisor mantissa 1.f
// o_busy  : iterating, o_done : one-cycle pulse, o_quo valid
// o_quo   : quotient, bit 17 is the integer bit
module div_man_25b (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic [17:0] i_num,
    input  logic [17:0] i_den,
    output logic        o_busy,
    output logic        o_done,
    output logic [17:0] o_quo
);
    // Partial remainder stays below twice the divisor, so 19 bits suffice.
    logic [18:0] rem;
    logic [17:0] den;
    logic [4:0]  cnt;
    logic        ge;
    logic [18:0] diff;

    always_comb begin
        ge   = rem >= {1'b0, den};
        diff = rem - {1'b0, den};
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rem    <= '0;
            den    <= '0;
            cnt    <= '0;
            o_busy <= 1'b0;
            o_done <= 1'b0;
            o_quo  <= '0;
        end else begin
            o_done <= 1'b0;
            if (i_start && !o_busy) begin
                rem    <= {1'b0, i_num};
                den    <= i_den;
                cnt    <= 5'd18;
                o_busy <= 1'b1;
                o_quo  <= '0;
            end else if (o_busy) begin
                rem   <= ge ? {diff[17:0], 1'b0} : {rem[17:0], 1'b0};
                o_quo <= {o_quo[16:0], ge};
                cnt   <= cnt - 5'd1;
                if (cnt == 5'd1) begin
                    o_busy <= 1'b0;
                    o_done <= 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/mlt_25b.sv
// rtl/mlt_25b.sv - combinational 25-bit float multiplier, truncating
// i_a, i_b : operands, o_p : product (zero if either operand is zero)
module mlt_25b
    import fmt_25b_pkg::*;
(
    input  word_t i_a,
    input  word_t i_b,
    output word_t o_p
);
    logic [35:0]       prod;
    logic [18:0]       top;
    logic signed [9:0] e;

    always_comb begin
        prod = {1'b1, i_a[16:0]} * {1'b1, i_b[16:0]};
        top  = 19'(prod >> 17);
        e    = $signed({2'b00, i_a[EXP_MSB:EXP_LSB]})
             + $signed({2'b00, i_b[EXP_MSB:EXP_LSB]}) - BIAS;
        if (is_zero(i_a) || is_zero(i_b))
            o_p = '0;
        else if (top[18])
            o_p = pack(i_a[SIGN_BIT] ^ i_b[SIGN_BIT], e + 10'sd1, top[17:1]);
        else
            o_p = pack(i_a[SIGN_BIT] ^ i_b[SIGN_BIT], e, top[16:0]);
    end
endmodule

// File: rtl/est_exp_25b.sv
// rtl/est_exp_25b.sv - recovers alpha/delta of an alpha*delta^t sample stream
// i_clk, i_rst (sync, active-high), i_start : restart estimation
// s_in    : sample stream (i_valid / i_val / o_ready)
// o_alpha : first sample, o_delta : x1/x0, o_done : estimate valid
// o_err   : sticky divide-by-zero or tracking mismatch
// o_cnt   : accepted samples, saturating
// Optional: EST_EXP_25B_REFIT_EN re-estimates delta on a tracking mismatch.
module est_exp_25b
    import fmt_25b_pkg::*;
#(
    parameter int P_TOL   = 2,
    parameter int P_CNT_W = 16
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    est_exp_25b_if.slave       s_in,
    output word_t              o_alpha,
    output word_t              o_delta,
    output logic               o_done,
    output logic               o_err,
    output logic [P_CNT_W-1:0] o_cnt
);
    state_t            state, nxt;
    logic              rdy, xfer, match;
    word_t             prev, num, den, pred, res;
    logic              div_go, div_busy, div_done;
    logic [17:0]       quo;
    logic [16:0]       fdiff;
    logic signed [9:0] e_div;

    assign xfer = s_in.i_valid && rdy;

    mlt_25b u_mlt (.i_a(prev), .i_b(o_delta), .o_p(pred));

    // i_start also abandons a division in flight.
    div_man_25b u_div (
        .i_clk  (i_clk),
        .i_rst  (i_rst || i_start),
        .i_start(div_go && !div_busy),
        .i_num  ({1'b1, num[16:0]}),
        .i_den  ({1'b1, den[16:0]}),
        .o_busy (div_busy),
        .o_done (div_done),
        .o_quo  (quo)
    );

    always_comb begin
        fdiff = (s_in.i_val[16:0] >= pred[16:0]) ? s_in.i_val[16:0] - pred[16:0]
                                                 : pred[16:0] - s_in.i_val[16:0];
        match = (s_in.i_val[SIGN_BIT] == pred[SIGN_BIT])
             && (s_in.i_val[EXP_MSB:EXP_LSB] == pred[EXP_MSB:EXP_LSB])
             && (fdiff <= 17'(P_TOL));
    end

    // Quotient below 1 is renormalised by one place; the result is truncated.
    always_comb begin
        e_div = $signed({2'b00, num[EXP_MSB:EXP_LSB]})
              - $signed({2'b00, den[EXP_MSB:EXP_LSB]}) + BIAS;
        if (is_zero(den) || is_zero(num))
            res = '0;
        else if (quo[17])
            res = pack(num[SIGN_BIT] ^ den[SIGN_BIT], e_div, quo[16:0]);
        else
            res = pack(num[SIGN_BIT] ^ den[SIGN_BIT], e_div - 10'sd1, {quo[15:0], 1'b0});
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= ST_IDLE;
        else       state <= nxt;
    end

    always_comb begin
        nxt = state;
        if (i_start) begin
            nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  if (xfer) nxt = ST_WAIT1;
                ST_WAIT1: if (xfer) nxt = ST_DIV;
                ST_DIV:   if (div_done) nxt = ST_TRACK;
                ST_TRACK: begin
`ifdef EST_EXP_25B_REFIT_EN
                    if (xfer && !match) nxt = ST_DIV;
`endif
                end
                default:  nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        rdy = (state != ST_DIV);
    end
    assign s_in.o_ready = rdy;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_alpha <= '0;
            o_delta <= '0;
            o_done  <= 1'b0;
            o_err   <= 1'b0;
            o_cnt   <= '0;
            prev    <= '0;
            num     <= '0;
            den     <= '0;
            div_go  <= 1'b0;
        end else if (i_start) begin
            o_done <= 1'b0;
            o_err  <= 1'b0;
            o_cnt  <= '0;
            div_go <= 1'b0;
        end else begin
            div_go <= 1'b0;
            if (xfer) begin
                prev <= s_in.i_val;
                if (o_cnt != '1) o_cnt <= o_cnt + 1'b1;
                case (state)
                    ST_IDLE: o_alpha <= s_in.i_val;
                    ST_WAIT1: begin
                        num    <= s_in.i_val;
                        den    <= prev;
                        div_go <= 1'b1;
                    end
                    ST_TRACK: begin
                        if (!match) begin
`ifdef EST_EXP_25B_REFIT_EN
                            num    <= s_in.i_val;
                            den    <= prev;
                            div_go <= 1'b1;
                            o_done <= 1'b0;
`else
                            o_err  <= 1'b1;
`endif
                        end
                    end
                    default: ;
                endcase
            end
            // den is the first sample of the segment being estimated.
            if (state == ST_DIV && div_done) begin
                o_delta <= res;
                o_alpha <= den;
                o_done  <= 1'b1;
                if (is_zero(den)) o_err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_est_exp_25b.sv
// tb/tb_est_exp_25b.sv - scoreboard bench for est_exp_25b
module tb_est_exp_25b;
    localparam logic [25:0] W_ONE  = 26'h0FE0000;
    localparam logic [25:0] W_HALF = 26'h0FC0000;
    localparam logic [25:0] W_QTR  = 26'h0FA0000;
    localparam logic [25:0] W_P75  = 26'h0FD0000;
    localparam logic [25:0] W_P56  = 26'h0FC4000;
    localparam logic [25:0] W_P375 = 26'h0FB0000;

    typedef struct {
        logic [25:0] alpha;
        logic [25:0] delta;
        logic        err;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [25:0] o_alpha, o_delta;
    logic        o_done, o_err;
    logic [3:0]  o_cnt;

    est_exp_25b_if bus ();

    est_exp_25b #(.P_TOL(2), .P_CNT_W(4)) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_start(start),
        .s_in   (bus),
        .o_alpha(o_alpha),
        .o_delta(o_delta),
        .o_done (o_done),
        .o_err  (o_err),
        .o_cnt  (o_cnt)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    int   xfer_cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    exp_t exp_q[$];
    logic done_q = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_chk++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, want);
    endtask

    // Monitor: every rising o_done is one estimate, compared in issue order.
    always @(negedge clk) begin
        if (!rst && o_done && !done_q) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 32'(o_delta), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("alpha", 32'(o_alpha), 32'(e.alpha));
                chk("delta", 32'(o_delta), 32'(e.delta));
                chk("err_at_done", 32'(o_err), 32'(e.err));
                chk("latency", 32'(cyc - xfer_cyc), 32'(e.lat));
            end
        end
        done_q = o_done;
    end

    task automatic send(input logic [25:0] v);
        int n;
        n = 0;
        @(negedge clk);
        bus.i_valid = 1'b1;
        bus.i_val   = v;
        while (!bus.o_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.o_ready) chk("send_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
        xfer_cyc = cyc;
        bus.i_valid = 1'b0;
    endtask

    task automatic start_pulse();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic push(input logic [25:0] a, input logic [25:0] d, input logic e);
        exp_t x;
        x.alpha = a;
        x.delta = d;
        x.err   = e;
        x.lat   = 20;
        exp_q.push_back(x);
    endtask

    task automatic wait_q();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            chk("done_timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rdy_seen;
        bus.i_valid = 1'b0;
        bus.i_val   = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_alpha", 32'(o_alpha), 32'd0);
        chk("rst_delta", 32'(o_delta), 32'd0);
        chk("rst_done",  32'(o_done), 32'd0);
        chk("rst_err",   32'(o_err), 32'd0);
        chk("rst_cnt",   32'(o_cnt), 32'd0);
        chk("rst_ready", 32'(bus.o_ready), 32'd1);

        // 1.0, 0.5, 0.25
        send(W_ONE);
        send(W_HALF);
        push(W_ONE, W_HALF, 1'b0);
        wait_q();
        send(W_QTR);
        chk("a_err", 32'(o_err), 32'd0);
        chk("a_cnt", 32'(o_cnt), 32'd3);

        // 1.0, 0.75, 0.5625
        start_pulse();
        send(W_ONE);
        send(W_P75);
        push(W_ONE, W_P75, 1'b0);
        wait_q();
        send(W_P56);
        chk("b_err", 32'(o_err), 32'd0);
        chk("b_cnt", 32'(o_cnt), 32'd3);

        // x0 zero
        start_pulse();
        send(26'h0000000);
        send(W_ONE);
        push(26'h0000000, 26'h0000000, 1'b1);
        wait_q();
        chk("c_err", 32'(o_err), 32'd1);

        // 1.0, 0.5, 0.375 tracking mismatch
        start_pulse();
        send(W_ONE);
        send(W_HALF);
        push(W_ONE, W_HALF, 1'b0);
        wait_q();
        send(W_P375);
`ifdef EST_EXP_25B_REFIT_EN
        chk("d_refit_ready", 32'(bus.o_ready), 32'd0);
        push(W_HALF, W_P75, 1'b0);
        wait_q();
        chk("d_err", 32'(o_err), 32'd0);
`else
        chk("d_err", 32'(o_err), 32'd1);
        repeat (25) @(negedge clk);
        chk("d_delta_kept", 32'(o_delta), 32'(W_HALF));
`endif

        // i_valid held during DIV
        start_pulse();
        send(W_ONE);
        send(W_HALF);
        push(W_ONE, W_HALF, 1'b0);
        bus.i_valid = 1'b1;
        bus.i_val   = W_QTR;
        rdy_seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.o_ready) rdy_seen++;
        end
        @(posedge clk);
        #1;
        bus.i_valid = 1'b0;
        chk("e_ready_low", 32'(rdy_seen), 32'd0);
        chk("e_cnt", 32'(o_cnt), 32'd2);
        chk("e_done", 32'(o_done), 32'd1);
        wait_q();

        // i_start mid-DIV
        start_pulse();
        send(W_ONE);
        send(W_HALF);
        repeat (5) @(posedge clk);
        start_pulse();
        chk("f_cnt", 32'(o_cnt), 32'd0);
        chk("f_done", 32'(o_done), 32'd0);
        chk("f_ready", 32'(bus.o_ready), 32'd1);
        repeat (30) @(negedge clk);
        chk("f_idle_ready", 32'(bus.o_ready), 32'd1);

        // counter saturation (4-bit counter)
        start_pulse();
        send(W_ONE);
        send(W_ONE);
        push(W_ONE, W_ONE, 1'b0);
        wait_q();
        for (int k = 0; k < 13; k++) send(W_ONE);
        chk("g_cnt_max", 32'(o_cnt), 32'd15);
        send(W_ONE);
        chk("g_cnt_sat", 32'(o_cnt), 32'd15);
        chk("g_err", 32'(o_err), 32'd0);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
